// File: rtl/ethpipe_pkg.sv
// Shared types and constants for the ethpipe receive-slot scheduler.
package ethpipe_pkg;

    localparam int LEN_W = 12;
    localparam int TS_W  = 32;

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_GUARD,
        ST_WAIT_FREE
    } rx_state_e;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [TS_W-1:0]  ts;
    } rx_desc_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ethpipe_irq_coal.sv
// Interrupt coalescer: fires on a pending-count threshold or after a quiet
// period with frames still pending; level output cleared by acknowledge.
module ethpipe_irq_coal
    import ethpipe_pkg::*;
#(
    parameter int SLOT_AW = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [SLOT_AW:0] count_i,
    input  logic             rx_complete_i,
    input  logic [SLOT_AW:0] irq_thresh_i,
    input  logic [15:0]      irq_timeout_i,
    input  logic             irq_ack_i,
    output logic             irq_o
);

    logic [15:0] idle_q, idle_d;
    logic        irq_q, irq_d;
    logic        fire;

    // Quiet-time counter and interrupt set/clear decision.
    always_comb begin
        idle_d = idle_q;
        if (rx_complete_i || irq_ack_i || (count_i == '0)) begin
            idle_d = '0;
        end else begin
            idle_d = sat_inc16(idle_q);
        end

        fire = ((irq_thresh_i != '0) && (count_i >= irq_thresh_i)) ||
               ((irq_timeout_i != '0) && (count_i != '0) && (idle_q == irq_timeout_i));

        irq_d = irq_q;
        if (irq_ack_i) begin
            irq_d = 1'b0;
        end else if (fire) begin
            irq_d = 1'b1;
        end
    end

    // Coalescer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            irq_q  <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/ethpipe_rx_slot_sched.sv
// Receive slot ring scheduler: grants the GMII receiver the next free slot,
// captures per-slot descriptors and presents the oldest filled slot to the host.
module ethpipe_rx_slot_sched
    import ethpipe_pkg::*;
#(
    parameter int SLOTS     = 4,
    parameter int SLOT_AW   = 2,
    parameter int GUARD_CYC = 4
) (
    input  logic               pci_clk,
    input  logic               sys_rst_n,
    input  logic               rx_complete,
    input  logic [LEN_W-1:0]   rx_frame_len,
    input  logic [TS_W-1:0]    rx_timestamp,
    output logic               rx_empty,
    output logic [SLOT_AW-1:0] rx_wr_slot,
    output logic               host_valid,
    output logic [SLOT_AW-1:0] host_rd_slot,
    output logic [LEN_W-1:0]   host_len,
    output logic [TS_W-1:0]    host_ts,
    input  logic               host_release,
    input  logic [SLOT_AW:0]   irq_thresh,
    input  logic [15:0]        irq_timeout,
    output logic               irq,
    input  logic               irq_ack,
    output logic [15:0]        full_events,
    output logic [1:0]         proto_err
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [SLOT_AW:0] PTR_ONE  = 1;
    localparam logic [SLOT_AW:0] PTR_FULL = SLOTS[SLOT_AW:0];

    rx_state_e        state_q, state_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [SLOT_AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [SLOT_AW:0] count;
    logic [15:0]      full_q, full_d;
    logic [1:0]       perr_q, perr_d;
    logic             rx_empty_q;
    logic             is_full;
    logic             accept;
    rx_desc_t         desc_q [SLOTS];
    rx_desc_t         rd_desc;

    // Slot state machine, pointer updates and sticky error capture.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        full_d  = full_q;
        perr_d  = perr_q;

        count   = wr_q - rd_q;
        is_full = (count == PTR_FULL);
        accept  = rx_complete && (state_q == ST_ARMED);

        if (host_release) begin
            if (count != '0) begin
                rd_d = rd_q + PTR_ONE;
            end else begin
                perr_d[1] = 1'b1;
            end
        end
        if (rx_complete && (state_q != ST_ARMED)) begin
            perr_d[0] = 1'b1;
        end

        case (state_q)
            ST_ARMED: begin
                if (rx_complete) begin
                    wr_d    = wr_q + PTR_ONE;
                    guard_d = GW'(GUARD_CYC - 1);
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_q != '0) begin
                    guard_d = guard_q - GW'(1);
                end else if (is_full) begin
                    state_d = ST_WAIT_FREE;
                    full_d  = sat_inc16(full_q);
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_WAIT_FREE: begin
                if (!is_full) begin
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
    end

    // Control state registers; rx_empty is registered from the next state.
    always_ff @(posedge pci_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_ARMED;
            guard_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            full_q     <= '0;
            perr_q     <= '0;
            rx_empty_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            full_q     <= full_d;
            perr_q     <= perr_d;
            rx_empty_q <= (state_d == ST_ARMED);
        end
    end

    // Descriptor capture on each accepted completion; contents are not reset.
    always_ff @(posedge pci_clk) begin
        if (accept) begin
            desc_q[wr_q[SLOT_AW-1:0]] <= rx_desc_t'{len: rx_frame_len, ts: rx_timestamp};
        end
    end

    ethpipe_irq_coal #(
        .SLOT_AW(SLOT_AW)
    ) u_irq_coal (
        .clk_i         (pci_clk),
        .rst_ni        (sys_rst_n),
        .count_i       (count),
        .rx_complete_i (rx_complete),
        .irq_thresh_i  (irq_thresh),
        .irq_timeout_i (irq_timeout),
        .irq_ack_i     (irq_ack),
        .irq_o         (irq)
    );

    // Host view is masked to zero while the ring is empty, since descriptors are never reset.
    assign rd_desc      = desc_q[rd_q[SLOT_AW-1:0]];
    assign host_valid   = (wr_q != rd_q);
    assign host_rd_slot = rd_q[SLOT_AW-1:0];
    assign host_len     = host_valid ? rd_desc.len : '0;
    assign host_ts      = host_valid ? rd_desc.ts  : '0;
    assign rx_wr_slot   = wr_q[SLOT_AW-1:0];
    assign rx_empty     = rx_empty_q;
    assign full_events  = full_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_ethpipe_rx_slot_sched.sv
// Self-checking bench for ethpipe_rx_slot_sched.
module tb_ethpipe_rx_slot_sched;

    localparam int SLOTS     = 4;
    localparam int SLOT_AW   = 2;
    localparam int GUARD_CYC = 4;

    logic               clk;
    logic               rst_n;
    logic               rx_complete;
    logic [11:0]        rx_frame_len;
    logic [31:0]        rx_timestamp;
    logic               rx_empty;
    logic [SLOT_AW-1:0] rx_wr_slot;
    logic               host_valid;
    logic [SLOT_AW-1:0] host_rd_slot;
    logic [11:0]        host_len;
    logic [31:0]        host_ts;
    logic               host_release;
    logic [SLOT_AW:0]   irq_thresh;
    logic [15:0]        irq_timeout;
    logic               irq;
    logic               irq_ack;
    logic [15:0]        full_events;
    logic [1:0]         proto_err;

    ethpipe_rx_slot_sched #(
        .SLOTS     (SLOTS),
        .SLOT_AW   (SLOT_AW),
        .GUARD_CYC (GUARD_CYC)
    ) dut (
        .pci_clk      (clk),
        .sys_rst_n    (rst_n),
        .rx_complete  (rx_complete),
        .rx_frame_len (rx_frame_len),
        .rx_timestamp (rx_timestamp),
        .rx_empty     (rx_empty),
        .rx_wr_slot   (rx_wr_slot),
        .host_valid   (host_valid),
        .host_rd_slot (host_rd_slot),
        .host_len     (host_len),
        .host_ts      (host_ts),
        .host_release (host_release),
        .irq_thresh   (irq_thresh),
        .irq_timeout  (irq_timeout),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .full_events  (full_events),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output selectors
    localparam int S_EMPTY = 0, S_WSLOT = 1, S_VALID = 2, S_RSLOT = 3, S_LEN = 4,
                   S_TS = 5, S_PERR = 6, S_IRQ = 7, S_FULL = 8;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        rxc;
        logic [11:0] len;
        logic [31:0] ts;
        logic        rel;
        logic        e_empty;
        logic [1:0]  e_ws;
        logic        e_valid;
        logic [1:0]  e_rs;
        logic [11:0] e_len;
        logic [31:0] e_ts;
        logic [1:0]  e_perr;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] probe(int sel);
        case (sel)
            S_EMPTY: return 32'(rx_empty);
            S_WSLOT: return 32'(rx_wr_slot);
            S_VALID: return 32'(host_valid);
            S_RSLOT: return 32'(host_rd_slot);
            S_LEN:   return 32'(host_len);
            S_TS:    return host_ts;
            S_PERR:  return 32'(proto_err);
            S_IRQ:   return 32'(irq);
            S_FULL:  return 32'(full_events);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_o(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = probe(e.sel);
            n_vec++;
            if (got !== e.val) begin
                n_err++;
                $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", e.name, $time, got, e.val);
            end
        end
    endtask

    // One clock of stimulus; queued expectations are checked 1 time unit after the edge.
    task automatic cycle(input logic rxc, input logic [11:0] len, input logic [31:0] ts,
                         input logic rel, input logic ack);
        rx_complete  = rxc;
        rx_frame_len = len;
        rx_timestamp = ts;
        host_release = rel;
        irq_ack      = ack;
        @(posedge clk);
        #1;
        rx_complete  = 1'b0;
        host_release = 1'b0;
        irq_ack      = 1'b0;
        check_sb();
    endtask

    task automatic idle();
        cycle(1'b0, 12'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic add_v(input logic rxc, input logic [11:0] len, input logic [31:0] ts,
                         input logic rel, input logic e_empty, input logic [1:0] e_ws,
                         input logic e_valid, input logic [1:0] e_rs, input logic [11:0] e_len,
                         input logic [31:0] e_ts, input logic [1:0] e_perr);
        vec_t v;
        v = '{rxc, len, ts, rel, e_empty, e_ws, e_valid, e_rs, e_len, e_ts, e_perr};
        vq.push_back(v);
    endtask

    task automatic expect_reset_values(input string tag);
        expect_o({tag, "_rx_empty"},   S_EMPTY, 32'd1);
        expect_o({tag, "_rx_wr_slot"}, S_WSLOT, 32'd0);
        expect_o({tag, "_host_valid"}, S_VALID, 32'd0);
        expect_o({tag, "_rd_slot"},    S_RSLOT, 32'd0);
        expect_o({tag, "_host_len"},   S_LEN,   32'd0);
        expect_o({tag, "_host_ts"},    S_TS,    32'd0);
        expect_o({tag, "_proto_err"},  S_PERR,  32'd0);
        expect_o({tag, "_irq"},        S_IRQ,   32'd0);
        expect_o({tag, "_full_ev"},    S_FULL,  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        rx_complete  = 1'b0;
        rx_frame_len = '0;
        rx_timestamp = '0;
        host_release = 1'b0;
        irq_ack      = 1'b0;
        irq_thresh   = '0;
        irq_timeout  = '0;

        // Table: single frame, stray completion, release when empty, simultaneous events.
        //     rxc len     ts            rel  empty ws valid rs len     ts            perr
        add_v(0, 12'h000, 32'h00000000, 0,   1, 0, 0, 0, 12'h000, 32'h00000000, 0);
        add_v(1, 12'h03C, 32'h12345678, 0,   0, 1, 1, 0, 12'h03C, 32'h12345678, 0);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 0, 12'h03C, 32'h12345678, 0);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 0, 12'h03C, 32'h12345678, 0);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 0, 12'h03C, 32'h12345678, 0);
        add_v(0, 12'h000, 32'h00000000, 0,   1, 1, 1, 0, 12'h03C, 32'h12345678, 0);
        add_v(0, 12'h000, 32'h00000000, 1,   1, 1, 0, 1, 12'h000, 32'h00000000, 0);
        add_v(1, 12'h100, 32'hAAAA0001, 0,   0, 2, 1, 1, 12'h100, 32'hAAAA0001, 0);
        add_v(1, 12'h7FF, 32'hDEADBEEF, 0,   0, 2, 1, 1, 12'h100, 32'hAAAA0001, 1);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 2, 1, 1, 12'h100, 32'hAAAA0001, 1);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 2, 1, 1, 12'h100, 32'hAAAA0001, 1);
        add_v(0, 12'h000, 32'h00000000, 0,   1, 2, 1, 1, 12'h100, 32'hAAAA0001, 1);
        add_v(0, 12'h000, 32'h00000000, 1,   1, 2, 0, 2, 12'h000, 32'h00000000, 1);
        add_v(0, 12'h000, 32'h00000000, 1,   1, 2, 0, 2, 12'h000, 32'h00000000, 3);
        add_v(1, 12'h040, 32'h00000010, 0,   0, 3, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 3, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 3, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 3, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   1, 3, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(1, 12'h041, 32'h00000011, 0,   0, 0, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 0, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 0, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 0, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   1, 0, 1, 2, 12'h040, 32'h00000010, 3);
        add_v(1, 12'h042, 32'h00000012, 1,   0, 1, 1, 3, 12'h041, 32'h00000011, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 3, 12'h041, 32'h00000011, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 3, 12'h041, 32'h00000011, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   0, 1, 1, 3, 12'h041, 32'h00000011, 3);
        add_v(0, 12'h000, 32'h00000000, 0,   1, 1, 1, 3, 12'h041, 32'h00000011, 3);
        add_v(0, 12'h000, 32'h00000000, 1,   1, 1, 1, 0, 12'h042, 32'h00000012, 3);
        add_v(0, 12'h000, 32'h00000000, 1,   1, 1, 0, 1, 12'h000, 32'h00000000, 3);

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        expect_reset_values("in_reset");
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            expect_o($sformatf("v%0d_rx_empty", i),   S_EMPTY, 32'(vq[i].e_empty));
            expect_o($sformatf("v%0d_rx_wr_slot", i), S_WSLOT, 32'(vq[i].e_ws));
            expect_o($sformatf("v%0d_host_valid", i), S_VALID, 32'(vq[i].e_valid));
            expect_o($sformatf("v%0d_rd_slot", i),    S_RSLOT, 32'(vq[i].e_rs));
            expect_o($sformatf("v%0d_host_len", i),   S_LEN,   32'(vq[i].e_len));
            expect_o($sformatf("v%0d_host_ts", i),    S_TS,    vq[i].e_ts);
            expect_o($sformatf("v%0d_proto_err", i),  S_PERR,  32'(vq[i].e_perr));
            cycle(vq[i].rxc, vq[i].len, vq[i].ts, vq[i].rel, 1'b0);
        end

        // Reset asserted mid-GUARD (wr=5 -> 6, slot 2)
        expect_o("rstg_rx_empty", S_EMPTY, 32'd0);
        expect_o("rstg_wr_slot",  S_WSLOT, 32'd2);
        cycle(1'b1, 12'h055, 32'h00000055, 1'b0, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_values("rst_async");
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;
        expect_o("rst_first_rx_empty", S_EMPTY, 32'd1);
        expect_o("rst_first_wr_slot",  S_WSLOT, 32'd0);
        expect_o("rst_first_valid",    S_VALID, 32'd0);
        idle();

        // Fill the ring without releasing
        for (int f = 0; f < SLOTS; f++) begin
            expect_o($sformatf("fill%0d_rx_empty", f), S_EMPTY, 32'd0);
            expect_o($sformatf("fill%0d_wr_slot", f),  S_WSLOT, 32'((f + 1) % SLOTS));
            expect_o($sformatf("fill%0d_full_ev", f),  S_FULL,  32'd0);
            cycle(1'b1, 12'(f + 1), 32'(f), 1'b0, 1'b0);
            for (int g = 0; g < GUARD_CYC - 1; g++) begin
                expect_o($sformatf("fill%0d_guard%0d", f, g), S_EMPTY, 32'd0);
                idle();
            end
            expect_o($sformatf("fill%0d_end_rx_empty", f), S_EMPTY, (f < SLOTS - 1) ? 32'd1 : 32'd0);
            expect_o($sformatf("fill%0d_end_full_ev", f),  S_FULL,  (f < SLOTS - 1) ? 32'd0 : 32'd1);
            idle();
        end
        for (int k = 0; k < 3; k++) begin
            expect_o($sformatf("wfree%0d_rx_empty", k), S_EMPTY, 32'd0);
            expect_o($sformatf("wfree%0d_full_ev", k),  S_FULL,  32'd1);
            expect_o($sformatf("wfree%0d_valid", k),    S_VALID, 32'd1);
            expect_o($sformatf("wfree%0d_len", k),      S_LEN,   32'd1);
            idle();
        end
        expect_o("full_rel_rx_empty", S_EMPTY, 32'd0);
        expect_o("full_rel_rd_slot",  S_RSLOT, 32'd1);
        expect_o("full_rel_len",      S_LEN,   32'd2);
        cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
        expect_o("rearm_rx_empty", S_EMPTY, 32'd1);
        expect_o("rearm_wr_slot",  S_WSLOT, 32'd0);
        expect_o("rearm_full_ev",  S_FULL,  32'd1);
        idle();
        for (int r = 0; r < 3; r++) begin
            expect_o($sformatf("drain%0d_valid", r),   S_VALID, (r < 2) ? 32'd1 : 32'd0);
            expect_o($sformatf("drain%0d_rd_slot", r), S_RSLOT, 32'((r + 2) % SLOTS));
            cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
        end

        // Threshold interrupt at three pending frames
        irq_thresh = 3'd3;
        for (int f = 0; f < 3; f++) begin
            expect_o($sformatf("thr%0d_irq_at_rxc", f), S_IRQ, 32'd0);
            cycle(1'b1, 12'(16 + f), 32'(f), 1'b0, 1'b0);
            for (int g = 0; g < GUARD_CYC; g++) begin
                expect_o($sformatf("thr%0d_irq_g%0d", f, g), S_IRQ, (f == 2) ? 32'd1 : 32'd0);
                idle();
            end
        end
        expect_o("thr_ack_irq", S_IRQ, 32'd0);
        cycle(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        expect_o("thr_refire_irq", S_IRQ, 32'd1);
        idle();
        irq_thresh = '0;
        for (int r = 0; r < 3; r++) begin
            expect_o($sformatf("thr_hold%0d_irq", r), S_IRQ, 32'd1);
            cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0);
        end
        expect_o("thr_clear_irq",   S_IRQ,   32'd0);
        expect_o("thr_clear_valid", S_VALID, 32'd0);
        cycle(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);

        // Timeout interrupt: idle_cnt reaches 100 in cycle N+101, irq registered in N+102
        irq_timeout = 16'd100;
        expect_o("tmo_irq_at_rxc", S_IRQ, 32'd0);
        cycle(1'b1, 12'h020, 32'h00000020, 1'b0, 1'b0);
        for (int j = 1; j <= 101; j++) begin
            expect_o($sformatf("tmo_irq_c%0d", j + 1), S_IRQ, (j == 101) ? 32'd1 : 32'd0);
            idle();
        end
        expect_o("tmo_ack_irq", S_IRQ, 32'd0);
        cycle(1'b0, 12'h0, 32'h0, 1'b0, 1'b1);
        expect_o("tmo_after_ack_irq", S_IRQ, 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
